barrel2_ctrl: RTL and testbench

- Request sequencer directly upstream of the registered barrel rotator stage (barrel2); owns that stage's Load, Select and Data_in.
- Accepts one job per valid/ready handshake: data word, rotate amount and step count.
- Loads the word, applies the rotate for the requested number of clock steps, captures the rotator's Data_out and returns it through a result handshake.
- Provides back-pressure so upstream logic never drives the barrel stage directly.

---
 rtl/barrel2_ctrl_if.sv | 33 +++
 rtl/barrel2_ctrl.sv | 103 ++++++++++
 tb/tb_barrel2_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/barrel2_ctrl_if.sv
// rtl/barrel2_ctrl_if.sv - job/result handshakes and barrel2 drive lines for barrel2_ctrl
interface barrel2_ctrl_if #(
  parameter int DATA_SIZE = 8,
  parameter int SEL_W     = 3,
  parameter int STEP_W    = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [DATA_SIZE-1:0] req_data;
  logic [SEL_W-1:0]     req_sel;
  logic [STEP_W-1:0]    req_steps;

  logic                 Load;
  logic [SEL_W-1:0]     Select;
  logic [DATA_SIZE-1:0] Data_in;
  logic [DATA_SIZE-1:0] brl_data;

  logic                 res_valid;
  logic                 res_ready;
  logic [DATA_SIZE-1:0] res_data;

  // Requester / result consumer / barrel side.
  modport master (
    output req_valid, req_data, req_sel, req_steps, res_ready, brl_data,
    input  req_ready, res_valid, res_data, Load, Select, Data_in
  );

  // Controller side.
  modport slave (
    input  req_valid, req_data, req_sel, req_steps, res_ready, brl_data,
    output req_ready, res_valid, res_data, Load, Select, Data_in
  );
endinterface

// File: rtl/barrel2_ctrl.sv
// rtl/barrel2_ctrl.sv - sequences one rotate job at a time through the registered barrel2 stage
module barrel2_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int SEL_W     = 3,
  parameter int STEP_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  barrel2_ctrl_if.slave bus,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [STEP_W-1:0]    cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] data_q;
  logic [SEL_W-1:0]     sel_q;
  logic [STEP_W-1:0]    steps_q;
  logic [DATA_SIZE-1:0] res_data_q;
  logic                 accept;
  logic                 capture;

  // Reset gates ready combinationally so it is low for the whole reset pulse.
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign capture       = (state_q == CAPTURE);

  assign bus.Data_in   = data_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_valid = (state_q == RESULT);
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Job registers only change on an accepted request, so Data_in holds the word afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      sel_q   <= '0;
      steps_q <= '0;
    end else if (accept) begin
      data_q  <= bus.req_data;
      sel_q   <= bus.req_sel;
      steps_q <= bus.req_steps;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data_q <= '0;
    end else if (capture) begin
      res_data_q <= bus.brl_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus.Load   = 1'b0;
    bus.Select = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        bus.Load = 1'b1;
        cnt_d    = steps_q;
        state_d  = (steps_q != '0) ? SHIFT : CAPTURE;
      end
      SHIFT: begin
        // One rotate edge per SHIFT cycle; leaving at count 1 yields exactly steps edges.
        bus.Select = sel_q;
        if (cnt_q != '0) cnt_d = cnt_q - STEP_W'(1);
        if (cnt_q <= STEP_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = RESULT;
      end
      RESULT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_barrel2_ctrl.sv
// tb/tb_barrel2_ctrl.sv - randomized self-checking bench for barrel2_ctrl with a barrel2 model
module tb_barrel2_ctrl;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  barrel2_ctrl_if #(.DATA_SIZE(DW), .SEL_W(SW), .STEP_W(TW)) bus ();

  barrel2_ctrl #(.DATA_SIZE(DW), .SEL_W(SW), .STEP_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  // Environment: the registered barrel stage the controller drives.
  logic [DW-1:0] brl_q;
  logic [DW-1:0] brl_src;
  assign brl_src      = bus.Load ? bus.Data_in : brl_q;
  assign bus.brl_data = brl_q;
  always @(posedge clk or posedge reset) begin
    if (reset) brl_q <= '0;
    else       brl_q <= (brl_src << bus.Select) | (brl_src >> (DW - int'(bus.Select)));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rot_ref(input int d, input int sel, input int steps);
    int a;
    a = (sel * steps) % DW;
    return ((d << a) | (d >> (DW - a))) & ((1 << DW) - 1);
  endfunction

  // Present a job and return just after its handshake edge.
  task automatic start_job(input int d, input int s, input int n);
    int w;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = DW'(d);
    bus.req_sel   = SW'(s);
    bus.req_steps = TW'(n);
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_job(input int d, input int s, input int n, input int gap, input bit hold);
    int loads, sels, cyc;
    bit seen;
    logic [DW-1:0] held;
    if (hold) bus.req_data = DW'($urandom);
    else      bus.req_valid = 1'b0;
    loads = 0; sels = 0; seen = 0; cyc = 0;
    for (int k = 0; k < 25 && !seen; k++) begin
      @(negedge clk);
      if (bus.Load) begin
        loads++;
        check("data_in_on_load", 32'(bus.Data_in), 32'(d));
      end
      if (bus.Select != '0) begin
        sels++;
        check("select_value", 32'(bus.Select), 32'(s));
      end
      if (bus.res_valid) begin
        seen = 1;
        cyc  = k;
      end
    end
    check("res_valid_seen", 32'(seen), 1);
    check("latency", 32'(cyc), 32'(2 + n));
    check("load_pulses", 32'(loads), 1);
    check("select_cycles", 32'(sels), (s != 0) ? 32'(n) : 0);
    check("res_data", 32'(bus.res_data), rot_ref(d, s, n));
    held = bus.res_data;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("bp_res_valid", 32'(bus.res_valid), 1);
      check("bp_res_data", 32'(bus.res_data), 32'(held));
      check("bp_select", 32'(bus.Select), 0);
      check("bp_req_ready", 32'(bus.req_ready), 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("post_res_valid", 32'(bus.res_valid), 0);
    check("post_busy", 32'(busy), 0);
    check("post_req_ready", 32'(bus.req_ready), 1);
    check("data_in_held", 32'(bus.Data_in), 32'(d));
  endtask

  task automatic run_job(input int d, input int s, input int n, input int gap, input bit hold);
    start_job(d, s, n);
    finish_job(d, s, n, gap, hold);
  endtask

  initial begin
    int d, s, n;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.req_sel   = '0;
    bus.req_steps = '0;
    bus.res_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_load", 32'(bus.Load), 0);
    check("rst_select", 32'(bus.Select), 0);
    check("rst_data_in", 32'(bus.Data_in), 0);
    check("rst_res_valid", 32'(bus.res_valid), 0);
    check("rst_res_data", 32'(bus.res_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rel_req_ready", 32'(bus.req_ready), 1);

    run_job(8'h81, 1, 3, 0, 0);
    run_job(8'hA5, 5, 0, 0, 0);
    run_job(8'h01, 2, 2, 6, 0);

    // Abort in SHIFT, then confirm the next job is clean.
    start_job(8'hF0, 3, 10);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_in_shift", 32'(bus.Select), 3);
    #2 reset = 1'b1;
    #1;
    check("abort_load", 32'(bus.Load), 0);
    check("abort_select", 32'(bus.Select), 0);
    check("abort_res_valid", 32'(bus.res_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_req_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("abort_no_result", 32'(bus.res_valid), 0);
    end
    run_job(8'h12, 4, 1, 1, 0);

    for (int j = 0; j < 200; j++) begin
      d = int'($urandom_range(0, 255));
      s = int'($urandom_range(0, 7));
      n = int'($urandom_range(0, 15));
      run_job(d, s, n, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
